trigger_network_ctrl: RTL

TRIGGER_NETWORK_CTRL -- requirements
Module: trigger_network_ctrl

---
 rtl/trigger_network_ctrl_if.sv | 36 +++
 rtl/trigger_network_ctrl.sv | 107 ++++++++++
 2 files changed

// File: rtl/trigger_network_ctrl_if.sv
// Port bundle between the trigger network controller and its host and per-actor trigger instances.
// Handshake: ap_start is a level request sampled only while ap_idle=1; ap_done and ap_ready pulse
// together for exactly one cycle when a run completes, and no back-pressure exists on either side.
interface trigger_network_ctrl_if #(
    parameter int NUM_ACTORS = 4
);
    logic                  ap_start;
    logic                  ap_done;
    logic                  ap_ready;
    logic                  ap_idle;
    logic [NUM_ACTORS-1:0] trig_sleep;
    logic [NUM_ACTORS-1:0] trig_sync_exec;
    logic [NUM_ACTORS-1:0] trig_sync_wait;
    logic [NUM_ACTORS-1:0] trig_waited;
    logic [NUM_ACTORS-1:0] trig_done;
    logic [NUM_ACTORS-1:0] trig_start;
    logic                  all_sleep;
    logic                  all_sync;
    logic                  all_sync_wait;
    logic [NUM_ACTORS-1:0] all_waited;
    logic [31:0]           run_cycles;
    logic [15:0]           sync_rounds;
    logic [1:0]            fsm_state;

    modport master (
        output ap_start, trig_sleep, trig_sync_exec, trig_sync_wait, trig_waited, trig_done,
        input  ap_done, ap_ready, ap_idle, trig_start, all_sleep, all_sync, all_sync_wait,
               all_waited, run_cycles, sync_rounds, fsm_state
    );

    modport slave (
        input  ap_start, trig_sleep, trig_sync_exec, trig_sync_wait, trig_waited, trig_done,
        output ap_done, ap_ready, ap_idle, trig_start, all_sleep, all_sync, all_sync_wait,
               all_waited, run_cycles, sync_rounds, fsm_state
    );
endinterface

// File: rtl/trigger_network_ctrl.sv
// Starts all actor triggers together, waits until each has reported done once, and aggregates
// the per-actor sleep/sync/waited flags into broadcast signals; also counts run cycles and sync rounds.
module trigger_network_ctrl #(
    parameter int NUM_ACTORS = 4
) (
    input  logic                   ap_clk,
    input  logic                   ap_rst,
    trigger_network_ctrl_if.slave  bus
);
    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_START = 2'd1,
        S_RUN   = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    localparam logic [NUM_ACTORS-1:0] ALL_ONES = '1;

    state_t                state_q;
    logic [NUM_ACTORS-1:0] done_flags_q;
    logic [31:0]           run_cnt_q;
    logic [15:0]           sync_cnt_q;
    logic                  sync_prev_q;
    logic                  start_q;
    logic                  done_q;
    logic                  idle_q;
    logic                  all_sync_c;
    logic [NUM_ACTORS-1:0] waited_excl_c;

    // Reductions are pure combinational functions of the trigger flags, independent of reset.
    assign all_sync_c = &(bus.trig_sync_exec | bus.trig_sync_wait);

    always_comb begin
        waited_excl_c = '0;
        for (int i = 0; i < NUM_ACTORS; i++) begin
            waited_excl_c[i] = &(bus.trig_waited | (NUM_ACTORS'(1) << i));
        end
    end

    assign bus.all_sleep     = &bus.trig_sleep;
    assign bus.all_sync      = all_sync_c;
    assign bus.all_sync_wait = &bus.trig_sync_wait;
    assign bus.all_waited    = waited_excl_c;

    always_ff @(posedge ap_clk) begin
        if (ap_rst) begin
            state_q      <= S_IDLE;
            done_flags_q <= '0;
            run_cnt_q    <= '0;
            sync_cnt_q   <= '0;
            sync_prev_q  <= 1'b0;
            start_q      <= 1'b0;
            done_q       <= 1'b0;
            idle_q       <= 1'b1;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (bus.ap_start) begin
                        state_q <= S_START;
                        start_q <= 1'b1;
                        idle_q  <= 1'b0;
                    end
                end
                S_START: begin
                    state_q      <= S_RUN;
                    done_flags_q <= '0;
                    run_cnt_q    <= '0;
                    sync_cnt_q   <= '0;
                    // A sync level already high on entry must not count as a round.
                    sync_prev_q  <= 1'b1;
                end
                S_RUN: begin
                    done_flags_q <= done_flags_q | bus.trig_done;
                    run_cnt_q    <= run_cnt_q + 32'd1;
                    sync_prev_q  <= all_sync_c;
                    if (all_sync_c && !sync_prev_q && (sync_cnt_q != 16'hFFFF)) begin
                        sync_cnt_q <= sync_cnt_q + 16'd1;
                    end
                    if (done_flags_q == ALL_ONES) begin
                        state_q <= S_DONE;
                        start_q <= 1'b0;
                        done_q  <= 1'b1;
                    end
                end
                S_DONE: begin
                    state_q <= S_IDLE;
                    done_q  <= 1'b0;
                    idle_q  <= 1'b1;
                end
                default: begin
                    state_q <= S_IDLE;
                    start_q <= 1'b0;
                    done_q  <= 1'b0;
                    idle_q  <= 1'b1;
                end
            endcase
        end
    end

    assign bus.trig_start  = {NUM_ACTORS{start_q}};
    assign bus.ap_done     = done_q;
    assign bus.ap_ready    = done_q;
    assign bus.ap_idle     = idle_q;
    assign bus.run_cycles  = run_cnt_q;
    assign bus.sync_rounds = sync_cnt_q;
    assign bus.fsm_state   = state_q;
endmodule
